// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: key encoding, key map
// and digit width matching the 8-digit display driver.
package keypad_scanner_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 8;

  typedef struct packed {
    logic               is_key;
    logic [DIGIT_W-1:0] code;
  } key_t;

  localparam key_t KEY_NONE = 5'b0_0000;

  // Indexed by {row, col}; element 0 is row 0 / col 0.
  localparam logic [15:0][DIGIT_W-1:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [DIGIT_W-1:0] key_lookup(input logic [1:0] row_idx,
                                                    input logic [1:0] col_idx);
    return KEY_MAP[{row_idx, col_idx}];
  endfunction

  // Columns are active-low; column 0 has priority.
  function automatic logic [1:0] lowest_low_col(input logic [3:0] col_s);
    if (!col_s[0])      return 2'd0;
    else if (!col_s[1]) return 2'd1;
    else if (!col_s[2]) return 2'd2;
    else                return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-facing pins plus the key/digit outputs that feed the display driver.
interface keypad_scanner_if;

  logic [3:0]                              col;
  logic                                    clr;
  logic [3:0]                              row;
  logic [keypad_scanner_pkg::DIGIT_W-1:0]  key_code;
  logic                                    key_valid;
  logic                                    key_held;
  logic [keypad_scanner_pkg::DIGIT_W-1:0]  seg0, seg1, seg2, seg3;
  logic [keypad_scanner_pkg::DIGIT_W-1:0]  seg4, seg5, seg6, seg7;

  // key_valid is a one-cycle strobe with no ready/back-pressure: the consumer
  // must take key_code in the cycle key_valid is high; there is no retry.
  modport slave (
    input  col, clr,
    output row, key_code, key_valid, key_held,
    output seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7
  );

  modport master (
    output col, clr,
    input  row, key_code, key_valid, key_held,
    input  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7
  );

endinterface

// File: rtl/keypad_scanner_debounce.sv
// Frame-level debouncer: tracks a candidate key over consecutive frame results
// and emits one acceptance per newly stable key.
module key_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic               ck,
  input  logic               rst_n,
  input  logic               frame_end,
  input  key_t               frame_result,
  output logic               accept,
  output logic [DIGIT_W-1:0] accept_code,
  output logic [DIGIT_W-1:0] key_code,
  output logic               key_valid,
  output logic               key_held
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  key_t               cand_q, cand_d;
  logic [3:0]         cnt_q, cnt_d;
  key_t               stable_q, stable_d;
  logic [DIGIT_W-1:0] key_code_q, key_code_d;
  logic               key_valid_q, key_valid_d;
  logic               reached;

  always_comb begin
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    stable_d    = stable_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    accept      = 1'b0;
    reached     = 1'b0;
    if (frame_end) begin
      if (frame_result == cand_q) begin
        if (cnt_q != DEB) cnt_d = cnt_q + 4'd1;
      end else begin
        cand_d = frame_result;
        cnt_d  = 4'd1;
      end
      // Only the edge into DEBOUNCE counts; a saturated count never re-fires.
      reached = (cnt_d == DEB) && ((cnt_q != DEB) || (cand_d != cand_q));
      if (reached && (cand_d != stable_q)) begin
        stable_d = cand_d;
        if (cand_d.is_key) begin
          accept      = 1'b1;
          key_code_d  = cand_d.code;
          key_valid_d = 1'b1;
        end
      end
    end
    accept_code = key_code_d;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      cand_q      <= KEY_NONE;
      cnt_q       <= 4'd0;
      stable_q    <= KEY_NONE;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      stable_q    <= stable_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = stable_q.is_key;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row strobing, column synchroniser, per-frame hit capture
// and an 8-nibble shift register of accepted keys for the display driver.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 100_000,
  parameter int DEBOUNCE = 4
) (
  input  logic             ck,
  input  logic             rst_n,
  keypad_scanner_if.slave  bus
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0]                      div_q, div_d;
  logic [1:0]                            row_idx_q, row_idx_d;
  logic [3:0]                            row_q, row_d;
  logic [3:0]                            sync1_q, sync1_d;
  logic [3:0]                            sync2_q, sync2_d;
  logic                                  hit_q, hit_d;
  logic [DIGIT_W-1:0]                    hit_code_q, hit_code_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]    seg_q, seg_d;
  logic                                  tick;
  logic                                  frame_end;
  key_t                                  frame_result;
  logic                                  accept;
  logic [DIGIT_W-1:0]                    accept_code;

  always_comb begin
    tick         = (div_q == DIV_W'(SCAN_DIV - 1));
    frame_end    = tick && (row_idx_q == 2'd3);
    div_d        = tick ? '0 : div_q + 1'b1;
    sync1_d      = bus.col;
    sync2_d      = sync1_q;
    row_idx_d    = row_idx_q;
    row_d        = row_q;
    hit_d        = hit_q;
    hit_code_d   = hit_code_q;
    frame_result = KEY_NONE;
    if (tick) begin
      // The first hit of a frame wins: earlier rows, then lower columns.
      if ((sync2_q != 4'hF) && !hit_q) begin
        hit_d      = 1'b1;
        hit_code_d = key_lookup(row_idx_q, lowest_low_col(sync2_q));
      end
      row_idx_d = row_idx_q + 2'd1;
      row_d     = ~(4'b0001 << row_idx_d);
      if (frame_end) begin
        frame_result.is_key = hit_d;
        frame_result.code   = hit_d ? hit_code_d : '0;
        hit_d               = 1'b0;
        hit_code_d          = '0;
      end
    end
  end

  always_comb begin
    seg_d = seg_q;
    if (bus.clr)     seg_d = '0;
    else if (accept) seg_d = {seg_q[NUM_DIGITS-2:0], accept_code};
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      row_idx_q  <= 2'd0;
      row_q      <= 4'b1110;
      sync1_q    <= 4'hF;
      sync2_q    <= 4'hF;
      hit_q      <= 1'b0;
      hit_code_q <= '0;
      seg_q      <= '0;
    end else begin
      div_q      <= div_d;
      row_idx_q  <= row_idx_d;
      row_q      <= row_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      hit_q      <= hit_d;
      hit_code_q <= hit_code_d;
      seg_q      <= seg_d;
    end
  end

  key_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .ck           (ck),
    .rst_n        (rst_n),
    .frame_end    (frame_end),
    .frame_result (frame_result),
    .accept       (accept),
    .accept_code  (accept_code),
    .key_code     (bus.key_code),
    .key_valid    (bus.key_valid),
    .key_held     (bus.key_held)
  );

  assign bus.row  = row_q;
  assign bus.seg0 = seg_q[0];
  assign bus.seg1 = seg_q[1];
  assign bus.seg2 = seg_q[2];
  assign bus.seg3 = seg_q[3];
  assign bus.seg4 = seg_q[4];
  assign bus.seg5 = seg_q[5];
  assign bus.seg6 = seg_q[6];
  assign bus.seg7 = seg_q[7];

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model driven frame by frame and a
// frame-level reference model built from the history of frame results.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  // ---------------- clock / reset ----------------
  logic ck = 1'b0;
  logic rst_n;
  always #5 ck = ~ck;

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEB)
  ) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (kif)
  );

  // Physical keypad: bit r*4+c set means key (row r, col c) is held down.
  logic [15:0] pressed;
  always_comb begin
    kif.col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!kif.row[r]) kif.col = ~pressed[r*4 +: 4];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int key_map [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};
  int hist[$];        // every frame result since reset, -1 = no key
  int m_stable;
  int m_code;
  int m_segs [8];
  bit m_pending;
  int checks;
  int errors;

  function automatic int frame_result(input logic [15:0] p);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (p[r*4+c]) return key_map[r][c];
    return -1;
  endfunction

  function automatic logic [15:0] key_bit(input int r, input int c);
    logic [15:0] one;
    one = 16'h0001;
    return one << (r*4 + c);
  endfunction

  task automatic model_reset();
    hist.delete();
    m_stable  = -1;
    m_code    = 0;
    m_pending = 1'b0;
    for (int i = 0; i < 8; i++) m_segs[i] = 0;
  endtask

  // A value becomes stable on the frame where its trailing run reaches DEB.
  task automatic model_frame_end(input bit clr_now);
    int res;
    int run;
    res = frame_result(pressed);
    hist.push_back(res);
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != res) break;
      run++;
    end
    m_pending = 1'b0;
    if (clr_now) for (int i = 0; i < 8; i++) m_segs[i] = 0;
    if (run == DEB && res != m_stable) begin
      m_stable = res;
      if (res >= 0) begin
        m_code    = res;
        m_pending = 1'b1;
        if (!clr_now) begin
          for (int i = 7; i > 0; i--) m_segs[i] = m_segs[i-1];
          m_segs[0] = res;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] get_seg(input int i);
    case (i)
      0: return kif.seg0;
      1: return kif.seg1;
      2: return kif.seg2;
      3: return kif.seg3;
      4: return kif.seg4;
      5: return kif.seg5;
      6: return kif.seg6;
      default: return kif.seg7;
    endcase
  endfunction

  task automatic check_state();
    chk("key_valid", kif.key_valid, 32'(m_pending));
    chk("key_code", kif.key_code, 32'(m_code));
    chk("key_held", kif.key_held, 32'(m_stable >= 0));
    for (int i = 0; i < 8; i++) chk($sformatf("seg%0d", i), get_seg(i), 32'(m_segs[i]));
  endtask

  task automatic check_reset();
    chk("rst_row", kif.row, 32'h0000_000E);
    chk("rst_key_code", kif.key_code, 32'h0);
    chk("rst_key_valid", kif.key_valid, 32'h0);
    chk("rst_key_held", kif.key_held, 32'h0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_seg%0d", i), get_seg(i), 32'h0);
  endtask

  // ---------------- driver ----------------
  // Called at the negedge of cycle 0 of a frame; returns at cycle 0 of the next.
  task automatic do_frame(input logic [15:0] keys, input bit clr_end, input int rst_at);
    logic [3:0] exp_row;
    pressed = keys;
    for (int c = 0; c < FRAME; c++) begin
      if (c == 0) check_state();
      else        chk("key_valid_idle", kif.key_valid, 32'h0);
      exp_row = ~(4'b0001 << (c / SCAN_DIV));
      chk("row", kif.row, 32'(exp_row));
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_reset();
        @(negedge ck);
        rst_n = 1'b1;
        model_reset();
        return;
      end
      if (c == FRAME - 1) kif.clr = clr_end;
      @(negedge ck);
      kif.clr = 1'b0;
    end
    model_frame_end(clr_end);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] cur;
    logic [15:0] both;
    int          left;
    checks  = 0;
    errors  = 0;
    pressed = '0;
    kif.clr = 1'b0;
    rst_n   = 1'b0;
    model_reset();
    repeat (3) @(negedge ck);
    check_reset();
    rst_n = 1'b1;

    // idle scan
    repeat (3) do_frame('0, 1'b0, -1);

    // single press of key 6, then release
    repeat (4) do_frame(key_bit(1, 2), 1'b0, -1);
    chk("single_code", kif.key_code, 32'h6);
    chk("single_held", kif.key_held, 32'h1);
    chk("single_seg0", kif.seg0, 32'h6);
    repeat (3) do_frame('0, 1'b0, -1);
    chk("release_held", kif.key_held, 32'h0);
    chk("release_code", kif.key_code, 32'h6);

    // bouncing key A
    do_frame(key_bit(0, 3), 1'b0, -1);
    do_frame('0, 1'b0, -1);
    do_frame(key_bit(0, 3), 1'b0, -1);
    repeat (3) do_frame(key_bit(0, 3), 1'b0, -1);
    chk("bounce_code", kif.key_code, 32'hA);
    repeat (3) do_frame('0, 1'b0, -1);

    // keys 1..9 shifted through the digit register
    for (int i = 1; i <= 9; i++) begin
      repeat (3) do_frame(key_bit((i - 1) / 3, (i - 1) % 3), 1'b0, -1);
      repeat (2) do_frame('0, 1'b0, -1);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("shift_seg%0d", i), get_seg(i), 32'(9 - i));

    // simultaneous press with clr landing on the shift edge
    both = key_bit(0, 1) | key_bit(3, 0);
    do_frame(both, 1'b0, -1);
    do_frame(both, 1'b1, -1);
    chk("simul_valid", kif.key_valid, 32'h1);
    chk("simul_code", kif.key_code, 32'h2);
    chk("simul_seg0", kif.seg0, 32'h0);
    chk("simul_seg7", kif.seg7, 32'h0);
    do_frame(both, 1'b0, -1);
    repeat (3) do_frame('0, 1'b0, -1);

    // async reset mid-debounce with the key still held
    do_frame(key_bit(2, 1), 1'b0, -1);
    do_frame(key_bit(2, 1), 1'b0, 6);
    repeat (3) do_frame(key_bit(2, 1), 1'b0, -1);
    chk("post_reset_code", kif.key_code, 32'h8);
    chk("post_reset_seg0", kif.seg0, 32'h8);
    repeat (3) do_frame('0, 1'b0, -1);

    // randomized key activity
    left = 0;
    cur  = '0;
    for (int f = 0; f < 48; f++) begin
      if (left == 0) begin
        case ($urandom_range(0, 3))
          0:       cur = '0;
          1, 2:    cur = key_bit($urandom_range(0, 3), $urandom_range(0, 3));
          default: cur = key_bit($urandom_range(0, 3), $urandom_range(0, 3)) |
                         key_bit($urandom_range(0, 3), $urandom_range(0, 3));
        endcase
        left = $urandom_range(1, 4);
      end
      do_frame(cur, ($urandom_range(0, 7) == 0), -1);
      left--;
    end
    do_frame('0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
